// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and the planned receiver.
// Latency: none (types, constants and a constant-evaluable helper only).
// Backpressure: none.
package uart_pkg;

  // Frame FSM states; PARITY is only reachable when parity generation is built in.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // 50 MHz core clock divided down to 115200 baud.
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  localparam int UART_DATA_BITS_MIN    = 5;
  localparam int UART_DATA_BITS_MAX    = 9;
  localparam int UART_STOP_BITS_MIN    = 1;
  localparam int UART_STOP_BITS_MAX    = 2;
  localparam int UART_CLKS_PER_BIT_MIN = 2;

  // True when a parameter set describes a frame this hardware can generate.
  function automatic bit uart_params_legal(input int data_bits,
                                           input int stop_bits,
                                           input int clks_per_bit);
    return (data_bits >= UART_DATA_BITS_MIN) && (data_bits <= UART_DATA_BITS_MAX) &&
           (stop_bits >= UART_STOP_BITS_MIN) && (stop_bits <= UART_STOP_BITS_MAX) &&
           (clks_per_bit >= UART_CLKS_PER_BIT_MIN);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// Latency: bit_done is combinational from the count; the count updates every clk.
// Backpressure: none; clear holds the count at zero while asserted.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done = (cnt_q == LAST);

  // Next count: wrap after the last cycle of a period, park at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Latency: tx drops to the start bit on the clk edge after an accept; tx is registered.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight.
// Build option: define UART_TX_PARITY_EN to append a parity bit (sense set by PARITY_ODD).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int               IDX_W         = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

  if (!uart_params_legal(DATA_BITS, STOP_BITS, CLKS_PER_BIT)) begin : g_param_err
    $error("uart_tx_serializer: illegal DATA_BITS/STOP_BITS/CLKS_PER_BIT");
  end

  uart_tx_state_t       state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 tx_q;
  logic                 tx_ready_q;
  logic                 busy_q;
  logic                 bit_done;
  logic                 baud_clear;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign accept   = tx_valid && tx_ready_q;
  assign tx_ready = tx_ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

  // The timer is parked at zero in IDLE so START gets a full first period. Every
  // other state change happens on bit_done, where the counter wraps to zero anyway.
  assign baud_clear = (state_q == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  // Frame FSM with registered line, handshake and busy outputs; bit_idx doubles
  // as the stop-bit counter once the data bits are out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q       <= 1'b1;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            state_q    <= START;
            shift_q    <= tx_data;
            bit_idx_q  <= '0;
            tx_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LAST_DATA_IDX) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q   <= STOP;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            if (bit_idx_q == LAST_STOP_IDX) begin
              state_q    <= IDLE;
              bit_idx_q  <= '0;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          bit_idx_q  <= '0;
          tx_q       <= 1'b1;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 and 2 stop bits, even and odd parity).
// Latency: expects the start bit on the edge after an accept.
// Backpressure: words are offered only when tx_ready is high, except the deliberate busy pulse.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P_EN = 1;
`else
  localparam int P_EN = 0;
`endif
  localparam int STOP_A  = 1;
  localparam int STOP_B  = 2;
  localparam int ODD_A   = 0;
  localparam int ODD_B   = 1;
  localparam int FRAME_A = (1 + DB + P_EN + STOP_A) * CPB;
  localparam int FRAME_B = (1 + DB + P_EN + STOP_B) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DB-1:0] dat_a = '0;
  logic [DB-1:0] dat_b = '0;
  logic          vld_a = 1'b0;
  logic          vld_b = 1'b0;
  logic          rdy_a, rdy_b, tx_a, tx_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DATA_BITS (DB), .CLKS_PER_BIT (CPB), .STOP_BITS (STOP_A), .PARITY_ODD (ODD_A)
  ) dut_a (
    .clk (clk), .rst (rst), .tx_data (dat_a), .tx_valid (vld_a),
    .tx_ready (rdy_a), .tx (tx_a), .busy (busy_a)
  );

  uart_tx_serializer #(
    .DATA_BITS (DB), .CLKS_PER_BIT (CPB), .STOP_BITS (STOP_B), .PARITY_ODD (ODD_B)
  ) dut_b (
    .clk (clk), .rst (rst), .tx_data (dat_b), .tx_valid (vld_b),
    .tx_ready (rdy_b), .tx (tx_b), .busy (busy_b)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_abort = 0;
  int         n_frames [2];
  int         last_gap [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic get_tx(input int d);
    return (d == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy_a : rdy_b;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] w);
    if (d == 0) begin
      vld_a = v;
      dat_a = w;
    end else begin
      vld_b = v;
      dat_b = w;
    end
  endtask

  task automatic push(input int d, input logic [7:0] w);
    if (d == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  // Decodes frames on one line, one sample per cycle, against the scoreboard.
  task automatic monitor(input int d);
    logic [15:0] bits;
    logic [3:0]  s;
    logic [7:0]  w;
    logic        par;
    int          nb;
    int          idle;
    bit          ab;
    nb   = 1 + DB + P_EN + ((d == 0) ? STOP_A : STOP_B);
    par  = (d == 0) ? ODD_A[0] : ODD_B[0];
    idle = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        idle = 0;
      end else if (get_tx(d) !== 1'b0) begin
        idle++;
      end else begin
        last_gap[d] = idle;
        idle = 0;
        w = 8'h00;
        if (d == 0 && exp_q0.size() > 0)      w = exp_q0.pop_front();
        else if (d == 1 && exp_q1.size() > 0) w = exp_q1.pop_front();
        else chk($sformatf("dut%0d_unexpected_frame", d), 32'd1, 32'd0);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) bits[1 + i] = w[i];
        if (P_EN != 0) bits[1 + DB] = (^w) ^ par;
        ab = 1'b0;
        for (int b = 0; b < nb && !ab; b++) begin
          s = '0;
          for (int c = 0; c < CPB && !ab; c++) begin
            if (b != 0 || c != 0) begin
              @(negedge clk);
              #1;
            end
            if (rst) ab = 1'b1;
            else     s[c] = get_tx(d);
          end
          if (!ab) chk($sformatf("dut%0d_frame%0d_bit%0d", d, n_frames[d], b),
                       32'(s), 32'({CPB{bits[b]}}));
        end
        if (ab) n_abort++;
        else    n_frames[d]++;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Offers one word when the block is ready, then checks the accept took effect.
  task automatic send(input int d, input logic [7:0] w);
    int n;
    n = 0;
    while (get_rdy(d) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d_ready_timeout", d), 32'(n < 200), 32'd1);
    drive(d, 1'b1, w);
    push(d, w);
    @(negedge clk);
    drive(d, 1'b0, 8'($urandom));
    chk($sformatf("dut%0d_accept_busy", d), 32'(get_busy(d)), 32'd1);
    chk($sformatf("dut%0d_accept_rdy", d), 32'(get_rdy(d)), 32'd0);
    chk($sformatf("dut%0d_start_latency", d), 32'(get_tx(d)), 32'd0);
  endtask

  // Counts cycles with tx_ready low from the cycle after an accept.
  task automatic measure(input int d, input int want);
    int n;
    n = 0;
    while (get_rdy(d) !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("dut%0d_frame_len", d), 32'(n), 32'(want));
    chk($sformatf("dut%0d_idle_tx", d), 32'(get_tx(d)), 32'd1);
    chk($sformatf("dut%0d_idle_busy", d), 32'(get_busy(d)), 32'd0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int n;
    n_frames[0] = 0;
    n_frames[1] = 0;
    last_gap[0] = -1;
    last_gap[1] = -1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_rdy_a", 32'(rdy_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    chk("rst_rdy_b", 32'(rdy_b), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy_a", 32'(rdy_a), 32'd1);
    chk("post_rst_rdy_b", 32'(rdy_b), 32'd1);

    // Framing and LSB-first order.
    send(0, 8'h55);
    measure(0, FRAME_A);

    // Parity sense on both instances.
    send(0, 8'hA5);
    measure(0, FRAME_A);
    send(1, 8'hA5);
    measure(1, FRAME_B);

    // Back-to-back words with tx_valid held high, two stop bits.
    @(negedge clk);
    drive(1, 1'b1, 8'h0F);
    push(1, 8'h0F);
    @(negedge clk);
    chk("b2b_first_busy", 32'(busy_b), 32'd1);
    drive(1, 1'b1, 8'hF0);
    push(1, 8'hF0);
    n = 0;
    while (rdy_b !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_len", 32'(n), 32'(FRAME_B));
    chk("b2b_idle_tx", 32'(tx_b), 32'd1);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    chk("b2b_second_start", 32'(tx_b), 32'd0);
    chk("b2b_second_busy", 32'(busy_b), 32'd1);
    measure(1, FRAME_B);
    chk("b2b_gap", 32'(last_gap[1]), 32'd1);

    // Ignore while busy: new data and a valid pulse during DATA.
    send(0, 8'h3C);
    repeat (10) @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    chk("busy_pulse_rdy", 32'(rdy_a), 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    chk("busy_pulse_busy", 32'(busy_a), 32'd1);
    measure(0, FRAME_A - 11);
    @(negedge clk);
    chk("busy_pulse_no_accept", 32'(tx_a), 32'd1);

    // Reset during the 4th data bit (bit3 of 0xC3 is 0).
    send(0, 8'hC3);
    repeat (17) @(negedge clk);
    chk("mid_bit3_tx", 32'(tx_a), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx_a), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_rdy", 32'(rdy_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_rdy", 32'(rdy_a), 32'd1);
    chk("mid_post_tx", 32'(tx_a), 32'd1);
    repeat (CPB * 3) @(negedge clk);
    chk("mid_no_resume_tx", 32'(tx_a), 32'd1);
    send(0, 8'h96);
    measure(0, FRAME_A);

    // Scoreboard drained and every frame accounted for.
    repeat (4) @(negedge clk);
    chk("sb_empty_a", 32'(exp_q0.size()), 32'd0);
    chk("sb_empty_b", 32'(exp_q1.size()), 32'd0);
    chk("frames_a", 32'(n_frames[0]), 32'd4);
    chk("frames_b", 32'(n_frames[1]), 32'd3);
    chk("aborted_frames", 32'(n_abort), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Parametrised UART transmitter. Serialises one parallel word per frame: start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits.
- Contains its own baud-rate counter, a shift register and a frame FSM.
- Accepts words over a valid/ready handshake from the host-side logic (command/response path).
- Drives the board TX pin directly from a register.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense (0 = even, 1 = odd); used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  in  1  system clock; the block uses this single clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  word to send; sampled only on an accept.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- tx  out  1  serial line, idle high, registered output.
- busy  out  1  high from the cycle after an accept until the frame returns to IDLE.

Behaviour:
- Reset:
  - rst is sampled on the clk edge (synchronous).
  - While rst is high at an edge: tx=1, tx_ready=0, busy=0, state=IDLE, counters=0.
  - tx_ready rises in the first cycle after rst deasserts.
- Accept rule: accept = tx_valid && tx_ready.
  - On an accept, tx_data is loaded into the shift register.
  - Any later change on tx_data is ignored until the next accept.
  - tx_valid is ignored in every state except IDLE.
- FSM states are IDLE, START, DATA, PARITY and STOP.
  - IDLE: tx=1, tx_ready=1. On an accept, go to START next cycle. tx=0 on the edge following the accept (1-cycle latency).
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment bit_idx (width $clog2(DATA_BITS+1)). After bit DATA_BITS-1, go to PARITY if parity is enabled, else to STOP.
  - PARITY: tx = XOR of the latched word, XORed with PARITY_ODD. Hold CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; bit_done fires at CLKS_PER_BIT-1, then the counter wraps to 0.
  - The counter is cleared on every state change and on reset.
- Frame timing:
  - One frame lasts (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
  - Back-to-back words with tx_valid held high have exactly one IDLE cycle (tx=1) between frames.
- Reset mid-frame: the frame is aborted at the next edge (tx=1, IDLE). No partial bits are resumed afterwards.
- Parameter checks: illegal DATA_BITS, STOP_BITS or CLKS_PER_BIT values stop elaboration with an error.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state exists and every frame carries a parity bit per PARITY_ODD.
- Undefined:
  - PARITY state and parity logic are removed.
  - DATA goes directly to STOP.
  - PARITY_ODD is ignored.
  - Frame length is 1 + DATA_BITS + STOP_BITS bit periods.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - localparams for the default baud divisor and the legal DATA_BITS/STOP_BITS ranges.
- The natural sub-module is uart_baud_counter (clk, rst, clear, bit_done). The planned RX block reuses it.

Test Plan:
- Framing and LSB-first order: CLKS_PER_BIT=4, DATA_BITS=8, parity disabled, send 0x55 → tx = 0 then 1,0,1,0,1,0,1,0 then 1. Each bit lasts 4 cycles; tx_ready=0 for 40 cycles.
- Parity, even: send 0xA5 with UART_TX_PARITY_EN defined and PARITY_ODD=0 → parity bit = 0; frame is 44 cycles.
- Parity, odd: same as above with PARITY_ODD=1 → parity bit = 1.
- Two stop bits and back-to-back words: STOP_BITS=2, send 0x0F then 0xF0 with tx_valid held high → 8 stop cycles, then exactly one idle cycle, then start of the second frame. Both words are received intact.
- Ignore while busy: change tx_data and pulse tx_valid during DATA → no accept occurs and the transmitted word is unchanged.
- Reset mid-frame: assert rst during the 4th data bit → tx=1 at the next edge and busy=0. tx_ready=1 in the first cycle after rst deasserts, and a new frame then transmits correctly.
